// File: rtl/tank_sprite_drawer.sv
// tank_sprite_drawer: two-stage sprite pipeline that maps the raster
// position onto a rotated tank sprite, looks it up in the tank ROM,
// applies the palette and blinks the sprite after a hit.
//
// Ports:
//   Clk, Reset         clock and synchronous active-high reset
//   DrawX, DrawY       current raster pixel from the VGA controller
//   vs                 vertical sync, active-low; its falling edge starts a frame
//   tank_x, tank_y     sprite top-left corner, latched at frame start
//   dir                facing direction (0 up, 1 right, 2 down, 3 left)
//   hit                one-cycle pulse that (re)starts the damage blink
//   rom_addr           registered tank ROM address (0 outside the sprite box)
//   rom_data           palette index returned combinationally by the ROM
//   sprite_on          output pixel is opaque tank
//   Red, Green, Blue   pixel colour, all zero when sprite_on is low
module tank_sprite_drawer #(
    parameter logic [15:0] BASE_ADDR = 16'h0000,
    parameter int          SPR_SIZE  = 64
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic        vs,
    input  logic [9:0]  tank_x,
    input  logic [9:0]  tank_y,
    input  logic [1:0]  dir,
    input  logic        hit,
    output logic [15:0] rom_addr,
    input  logic [3:0]  rom_data,
    output logic        sprite_on,
    output logic [7:0]  Red,
    output logic [7:0]  Green,
    output logic [7:0]  Blue
);

    localparam int          IW     = $clog2(SPR_SIZE);
    localparam logic [10:0] SIZE11 = 11'(SPR_SIZE);
    localparam logic [IW-1:0] NMAX = IW'(SPR_SIZE - 1);

    // ------------------------------------------------------------
    // Frame boundary detection and per-frame latches
    // ------------------------------------------------------------
    logic       vs_q;
    logic       frame_start;
    logic [9:0] fx;
    logic [9:0] fy;
    logic [1:0] fdir;

    assign frame_start = vs_q & ~vs;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            vs_q <= 1'b1;
            fx   <= '0;
            fy   <= '0;
            fdir <= '0;
        end else begin
            vs_q <= vs;
            if (frame_start) begin
                fx   <= tank_x;
                fy   <= tank_y;
                fdir <= dir;
            end
        end
    end

    // ------------------------------------------------------------
    // Damage blink: 32 frames, alternating 4 shown / 4 hidden
    // ------------------------------------------------------------
    logic [5:0] blink_cnt;
    logic       blank_now;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            blink_cnt <= '0;
        end else if (hit) begin
            // A hit always restarts the sequence, even on a frame edge.
            blink_cnt <= 6'd32;
        end else if (frame_start && blink_cnt != 6'd0) begin
            blink_cnt <= blink_cnt - 6'd1;
        end
    end

    assign blank_now = (blink_cnt != 6'd0) && blink_cnt[2];

    // ------------------------------------------------------------
    // Stage 1: box test, rotation and ROM address
    // ------------------------------------------------------------
    logic [10:0]   x11;
    logic [10:0]   y11;
    logic [10:0]   fx11;
    logic [10:0]   fy11;
    logic          inbox;
    logic [IW-1:0] r;
    logic [IW-1:0] c;
    logic [IW-1:0] sr;
    logic [IW-1:0] sc;
    logic [15:0]   offs;
    logic          vld1;

    // 11-bit compares so a sprite near the right/bottom edge does not
    // wrap onto low coordinates.
    assign x11  = {1'b0, DrawX};
    assign y11  = {1'b0, DrawY};
    assign fx11 = {1'b0, fx};
    assign fy11 = {1'b0, fy};

    assign inbox = (x11 >= fx11) && (x11 < fx11 + SIZE11) &&
                   (y11 >= fy11) && (y11 < fy11 + SIZE11);

    // Only the low bits matter inside the box.
    assign r = DrawY[IW-1:0] - fy[IW-1:0];
    assign c = DrawX[IW-1:0] - fx[IW-1:0];

    always_comb begin
        sr = r;
        sc = c;
        case (fdir)
            2'd0: begin
                sr = r;
                sc = c;
            end
            2'd1: begin
                sr = NMAX - c;
                sc = r;
            end
            2'd2: begin
                sr = NMAX - r;
                sc = NMAX - c;
            end
            2'd3: begin
                sr = c;
                sc = NMAX - r;
            end
            default: begin
                sr = r;
                sc = c;
            end
        endcase
    end

    // SPR_SIZE is a power of two, so sr*SPR_SIZE+sc is a concatenation.
    assign offs = 16'({sr, sc});

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_addr <= '0;
            vld1     <= 1'b0;
        end else begin
            vld1     <= inbox;
            rom_addr <= inbox ? (BASE_ADDR + offs) : 16'h0000;
        end
    end

    // ------------------------------------------------------------
    // Stage 2: palette lookup and output registers
    // ------------------------------------------------------------
    function automatic logic [23:0] palette(input logic [3:0] idx);
        logic [23:0] rgb;
        case (idx)
            4'd0:    rgb = 24'h000000;
            4'd1:    rgb = 24'h202020;
            4'd2:    rgb = 24'h606060;
            4'd3:    rgb = 24'hA0A0A0;
            4'd4:    rgb = 24'h1E5A1E;
            4'd5:    rgb = 24'h3C8C3C;
            4'd6:    rgb = 24'h6EC86E;
            default: rgb = 24'hFF00FF;
        endcase
        return rgb;
    endfunction

    logic        on_next;
    logic [23:0] rgb_next;

    always_comb begin
        on_next  = vld1 && (rom_data != 4'd0) && !blank_now;
        rgb_next = 24'h000000;
        if (on_next) begin
            rgb_next = palette(rom_data);
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            sprite_on <= 1'b0;
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
        end else begin
            sprite_on <= on_next;
            Red       <= rgb_next[23:16];
            Green     <= rgb_next[15:8];
            Blue      <= rgb_next[7:0];
        end
    end

endmodule

// File: tb/tb_tank_sprite_drawer.sv
// tb_tank_sprite_drawer: directed bench for tank_sprite_drawer covering
// frame latching, rotation, box bounds, palette, blink and reset.
module tb_tank_sprite_drawer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic [9:0]  DrawX;
    logic [9:0]  DrawY;
    logic        vs;
    logic [9:0]  tank_x;
    logic [9:0]  tank_y;
    logic [1:0]  dir;
    logic        hit;
    logic [15:0] rom_addr;
    logic [3:0]  rom_data;
    logic        sprite_on;
    logic [7:0]  Red;
    logic [7:0]  Green;
    logic [7:0]  Blue;

    int checks = 0;
    int errors = 0;

    tank_sprite_drawer dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .DrawX    (DrawX),
        .DrawY    (DrawY),
        .vs       (vs),
        .tank_x   (tank_x),
        .tank_y   (tank_y),
        .dir      (dir),
        .hit      (hit),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .sprite_on(sprite_on),
        .Red      (Red),
        .Green    (Green),
        .Blue     (Blue)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic new_frame(input logic [9:0] x, input logic [9:0] y,
                             input logic [1:0] d);
        tank_x = x;
        tank_y = y;
        dir    = d;
        vs     = 1'b0;
        tick();
        vs = 1'b1;
        tick();
    endtask

    // Present one pixel, check the address after one edge and the
    // output pixel after the second.
    task automatic pixel(input string tag, input logic [9:0] x,
                         input logic [9:0] y, input logic [3:0] data,
                         input logic [15:0] exp_addr, input logic exp_on,
                         input logic [23:0] exp_rgb);
        DrawX    = x;
        DrawY    = y;
        rom_data = data;
        tick();
        check({tag, "_addr"}, 32'(rom_addr), 32'(exp_addr));
        tick();
        check({tag, "_on"}, 32'(sprite_on), 32'(exp_on));
        check({tag, "_rgb"}, 32'({Red, Green, Blue}), 32'(exp_rgb));
    endtask

    task automatic blink_pix(input string tag, input logic exp_on);
        DrawX    = 10'd110;
        DrawY    = 10'd55;
        rom_data = 4'd5;
        tick();
        tick();
        check(tag, 32'(sprite_on), 32'(exp_on));
    endtask

    initial begin
        Reset    = 1'b1;
        DrawX    = '0;
        DrawY    = '0;
        vs       = 1'b1;
        tank_x   = '0;
        tank_y   = '0;
        dir      = '0;
        hit      = 1'b0;
        rom_data = '0;
        tick();
        tick();
        check("rst_addr", 32'(rom_addr), 32'h0);
        check("rst_on", 32'(sprite_on), 32'h0);
        check("rst_rgb", 32'({Red, Green, Blue}), 32'h0);
        check("rst_cnt", 32'(dut.blink_cnt), 32'h0);
        Reset = 1'b0;

        // Frame latch; later tank_x change must not affect this frame
        new_frame(10'd100, 10'd50, 2'd0);
        tank_x = 10'd300;
        pixel("latch", 10'd100, 10'd50, 4'd5, 16'h0000, 1'b1, 24'h3C8C3C);
        pixel("right_in", 10'd163, 10'd50, 4'd5, 16'h003F, 1'b1, 24'h3C8C3C);
        pixel("right_out", 10'd164, 10'd50, 4'd5, 16'h0000, 1'b0, 24'h0);
        pixel("left_out", 10'd99, 10'd50, 4'd5, 16'h0000, 1'b0, 24'h0);
        pixel("bot_in", 10'd100, 10'd113, 4'd5, 16'h0FC0, 1'b1, 24'h3C8C3C);
        pixel("bot_out", 10'd100, 10'd114, 4'd5, 16'h0000, 1'b0, 24'h0);

        // Palette
        pixel("pal0", 10'd120, 10'd60, 4'd0, 16'h0294, 1'b0, 24'h0);
        pixel("pal9", 10'd120, 10'd60, 4'd9, 16'h0294, 1'b1, 24'hFF00FF);
        pixel("pal1", 10'd120, 10'd60, 4'd1, 16'h0294, 1'b1, 24'h202020);
        pixel("pal6", 10'd120, 10'd60, 4'd6, 16'h0294, 1'b1, 24'h6EC86E);
        pixel("pal4", 10'd120, 10'd60, 4'd4, 16'h0294, 1'b1, 24'h1E5A1E);
        pixel("pal15", 10'd120, 10'd60, 4'd15, 16'h0294, 1'b1, 24'hFF00FF);

        // Rotation
        new_frame(10'd0, 10'd0, 2'd0);
        pixel("rot0", 10'd5, 10'd2, 4'd3, 16'h0085, 1'b1, 24'hA0A0A0);
        new_frame(10'd0, 10'd0, 2'd1);
        pixel("rot1", 10'd5, 10'd2, 4'd2, 16'h0E82, 1'b1, 24'h606060);
        new_frame(10'd0, 10'd0, 2'd2);
        pixel("rot2", 10'd5, 10'd2, 4'd3, 16'h0F7A, 1'b1, 24'hA0A0A0);
        new_frame(10'd0, 10'd0, 2'd3);
        pixel("rot3", 10'd5, 10'd2, 4'd3, 16'h017D, 1'b1, 24'hA0A0A0);

        // No wrap near the right edge
        new_frame(10'd1000, 10'd0, 2'd0);
        pixel("nowrap", 10'd10, 10'd5, 4'd5, 16'h0000, 1'b0, 24'h0);
        pixel("edge_in", 10'd1010, 10'd5, 4'd5, 16'h014A, 1'b1, 24'h3C8C3C);

        // Blink
        new_frame(10'd100, 10'd50, 2'd0);
        blink_pix("blink_idle", 1'b1);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("hit_cnt", 32'(dut.blink_cnt), 32'd32);
        blink_pix("blink_32", 1'b1);
        for (int i = 31; i >= 28; i--) begin
            new_frame(10'd100, 10'd50, 2'd0);
            blink_pix($sformatf("blink_%0d", i), 1'b0);
        end
        new_frame(10'd100, 10'd50, 2'd0);
        blink_pix("blink_27", 1'b1);
        for (int i = 0; i < 27; i++) begin
            new_frame(10'd100, 10'd50, 2'd0);
        end
        check("blink_zero", 32'(dut.blink_cnt), 32'd0);
        blink_pix("blink_done", 1'b1);
        new_frame(10'd100, 10'd50, 2'd0);
        check("blink_hold0", 32'(dut.blink_cnt), 32'd0);

        // Hit coinciding with frame start
        hit = 1'b1;
        vs  = 1'b0;
        tick();
        hit = 1'b0;
        vs  = 1'b1;
        tick();
        check("hit_fs_cnt", 32'(dut.blink_cnt), 32'd32);
        new_frame(10'd100, 10'd50, 2'd0);
        check("dec_31", 32'(dut.blink_cnt), 32'd31);
        hit = 1'b1;
        tick();
        hit = 1'b0;
        check("reload", 32'(dut.blink_cnt), 32'd32);

        // Reset mid-stream
        blink_pix("pre_rst", 1'b1);
        Reset = 1'b1;
        tick();
        check("mrst_on", 32'(sprite_on), 32'h0);
        check("mrst_addr", 32'(rom_addr), 32'h0);
        check("mrst_rgb", 32'({Red, Green, Blue}), 32'h0);
        check("mrst_fx", 32'(dut.fx), 32'h0);
        check("mrst_cnt", 32'(dut.blink_cnt), 32'h0);
        DrawX    = 10'd5;
        DrawY    = 10'd2;
        rom_data = 4'd5;
        Reset    = 1'b0;
        tick();
        check("refill1_addr", 32'(rom_addr), 32'h0085);
        check("refill1_on", 32'(sprite_on), 32'h0);
        tick();
        check("refill2_on", 32'(sprite_on), 32'h1);
        check("refill2_fx", 32'(dut.fx), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tank_sprite_drawer.md
TANK_SPRITE_DRAWER -- requirements
Module: tank_sprite_drawer

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h0000: sprite-sheet base address in the tank ROM.
REQ-002 SHALL have parameter SPR_SIZE, default 64: sprite width and height in pixels; power of two, at most 128.
REQ-003 SHALL have port Clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 SHALL have port Reset, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports DrawX and DrawY, inputs, 10 bits each: current raster pixel from the VGA controller.
REQ-006 SHALL have port vs, input, 1 bit: vertical sync, active-low.
REQ-007 SHALL have ports tank_x and tank_y, inputs, 10 bits each: sprite top-left corner from the tank motion logic.
REQ-008 SHALL have port dir, input, 2 bits: facing direction; 0 up, 1 right, 2 down, 3 left.
REQ-009 SHALL have port hit, input, 1 bit: single-cycle pulse that starts the damage blink.
REQ-010 SHALL have port rom_addr, output, 16 bits: registered address to the tank ROM.
REQ-011 SHALL have port rom_data, input, 4 bits: palette index returned combinationally by the tank ROM.
REQ-012 SHALL have port sprite_on, output, 1 bit: the current output pixel is opaque tank.
REQ-013 SHALL have ports Red, Green and Blue, outputs, 8 bits each: pixel colour, valid when sprite_on=1.

Function
REQ-014 SHALL register vs each cycle and detect its falling edge (frame_start).
REQ-015 SHALL latch tank_x, tank_y and dir into frame registers only on frame_start; inputs outside that edge SHALL have no effect on the current frame.
REQ-016 Stage 1 SHALL compute inbox = (DrawX >= fx) AND (DrawX < fx+SPR_SIZE) AND the same for Y, using 11-bit compares with no wrap.
- Stage 1 SHALL also compute r = DrawY-fy and c = DrawX-fx.
REQ-017 Stage 1 SHALL select the source pixel (sr,sc) by latched dir, with N=SPR_SIZE-1:
- dir 0: (r, c)
- dir 1: (N-c, r)
- dir 2: (N-r, N-c)
- dir 3: (c, N-r)
REQ-018 SHALL register rom_addr = BASE_ADDR + sr*SPR_SIZE + sc, truncated to 16 bits, together with a valid bit equal to inbox; rom_addr SHALL be 0 when inbox=0.
REQ-019 Stage 2 SHALL register the outputs from rom_data and the stage-1 valid bit:
- sprite_on = valid AND rom_data != 0 AND NOT blank_now.
- Total latency from DrawX/DrawY to outputs: 2 cycles, fully pipelined, one pixel per cycle.
REQ-020 Palette (24-bit RGB) SHALL be:
- 0: transparent, outputs 0.
- 1: 202020; 2: 606060; 3: A0A0A0; 4: 1E5A1E; 5: 3C8C3C; 6: 6EC86E.
- 7-15: FF00FF.
REQ-021 When sprite_on=0, Red, Green and Blue SHALL all be 0.
REQ-022 The blink counter SHALL be 6 bits:
- hit loads 32.
- frame_start with counter>0 decrements it by 1.
- hit coinciding with frame_start loads 32 (load wins).
- hit while counter>0 reloads 32.
REQ-023 blank_now SHALL be (counter != 0) AND counter[2]=1, giving 4 frames hidden / 4 frames shown.

Reset
REQ-024 On Reset=1 at a clock edge, SHALL clear:
- rom_addr, sprite_on, Red, Green, Blue.
- All pipeline valid bits.
- fx, fy, fdir and the vs history register (set to 1).
- The blink counter.
REQ-025 Reset asserted mid-frame SHALL drop sprite_on on the next edge, and the pipeline SHALL resume after a clean 2-cycle refill.

Verification
REQ-026 Frame latch: tank_x=100, tank_y=50, dir=0 set, then vs falling edge; DrawX=100, DrawY=50 -> rom_addr=0x0000 one cycle later; sprite_on follows rom_data!=0 after two cycles.
REQ-027 Rotation: fx=0, fy=0, DrawX=5, DrawY=2 with dir 0/1/2/3 -> rom_addr 0x0085 / 0x0E82 / 0x0F7A / 0x017D.
REQ-028 Bounds: DrawX=163 with fx=100 -> sprite_on=1 if data nonzero; DrawX=164 -> sprite_on=0 and rom_addr=0.
- tank_x=1000 -> no wrap onto left columns.
REQ-029 Palette: rom_data=5 in box -> RGB 3C,8C,3C; rom_data=0 -> sprite_on=0 and RGB 0; rom_data=9 -> FF,00,FF.
REQ-030 Blink: hit pulse -> counter=32; on frames with counter 31..28 sprite suppressed; counter reaches 0 after 32 frame_starts; hit on the same cycle as frame_start -> counter=32.
REQ-031 Reset mid-stream: Reset during in-box pixels -> all outputs 0 next cycle; fx=fy=0 until next frame_start.
